// File: rtl/ifetch32.sv
`timescale 1ns/1ps
// ifetch32: instruction fetch and PC sequencer feeding the decoder, with branch redirect and link write.
// Optional feature macro IFETCH_PREFETCH_EN adds a 2-entry prefetch FIFO and a DRAIN state.
module ifetch32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [3:0]  LINK_REG = 4'd14
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] i_out,
    output logic        i_valid_out,
    output logic        ispb_out,
    output logic [31:0] pc_out,
    input  logic        stall_in,
    input  logic        ib_in,
    input  logic [31:0] bv_in,
    input  logic        bl_in,
    output logic        link_we_out,
    output logic [3:0]  link_addr_out,
    output logic [31:0] link_data_out
);

`ifdef IFETCH_PREFETCH_EN
    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;
`else
    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;
`endif

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] fetch_pc_r;
    logic        ispb_pend_r;
    logic        req_s;
    logic        ack_s;
    logic        consume_s;
    logic        take_s;
    logic [31:0] target_s;

    assign consume_s     = i_valid_out & ~stall_in;
    assign take_s        = consume_s & ib_in;
    assign target_s      = pc_out + 32'd8 + bv_in;
    assign ack_s         = req_s & imem_ack_in;
    assign imem_req_out  = req_s;
    assign imem_addr_out = fetch_pc_r;
    assign link_addr_out = LINK_REG;

`ifdef IFETCH_PREFETCH_EN
    logic [31:0] fifo_data_r [2];
    logic [31:0] fifo_pc_r [2];
    logic [1:0]  fifo_pb_r;
    logic [1:0]  fifo_cnt_r;
    logic [31:0] target_r;
    logic        out_free_s;
    logic        pop_s;
    logic        push_s;
    logic        wr_idx_s;

    // Ack data bypasses the FIFO straight into i_out when the output slot frees and the FIFO is empty.
    assign out_free_s = ~i_valid_out | consume_s;
    assign pop_s      = out_free_s & (fifo_cnt_r != 2'd0);
    assign push_s     = ack_s & (state_r == FETCH) & ~take_s & ~(out_free_s & (fifo_cnt_r == 2'd0));
    assign wr_idx_s   = (fifo_cnt_r == 2'd2) | ((fifo_cnt_r == 2'd1) & ~pop_s);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
`ifdef IFETCH_PREFETCH_EN
            FETCH:   if (take_s && req_s && !imem_ack_in) state_nxt_s = DRAIN; else state_nxt_s = FETCH;
            DRAIN:   if (ack_s) state_nxt_s = FETCH; else state_nxt_s = DRAIN;
`else
            FETCH:   if (ack_s) state_nxt_s = HOLD; else state_nxt_s = FETCH;
            HOLD:    if (consume_s) state_nxt_s = FETCH; else state_nxt_s = HOLD;
`endif
            default: state_nxt_s = FETCH;
        endcase
    end

    // Request is gated by rst_n so it drops in the same cycle reset asserts.
    always_comb begin
        req_s = 1'b0;
        case (state_r)
`ifdef IFETCH_PREFETCH_EN
            FETCH:   req_s = rst_n & (fifo_cnt_r != 2'd2);
            DRAIN:   req_s = rst_n;
`else
            FETCH:   req_s = rst_n;
            HOLD:    req_s = 1'b0;
`endif
            default: req_s = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            ispb_pend_r   <= 1'b0;
            i_out         <= 32'd0;
            i_valid_out   <= 1'b0;
            ispb_out      <= 1'b0;
            pc_out        <= RESET_PC;
            link_we_out   <= 1'b0;
            link_data_out <= 32'd0;
`ifdef IFETCH_PREFETCH_EN
            fifo_data_r[0] <= 32'd0;
            fifo_data_r[1] <= 32'd0;
            fifo_pc_r[0]   <= 32'd0;
            fifo_pc_r[1]   <= 32'd0;
            fifo_pb_r      <= 2'd0;
            fifo_cnt_r     <= 2'd0;
            target_r       <= 32'd0;
`endif
        end else begin
            link_we_out <= take_s & bl_in;
            if (take_s && bl_in) begin
                link_data_out <= pc_out + 32'd4;
            end
`ifdef IFETCH_PREFETCH_EN
            if (take_s) begin
                i_valid_out <= 1'b0;
                ispb_out    <= 1'b0;
                fifo_cnt_r  <= 2'd0;
                ispb_pend_r <= 1'b1;
                if (req_s && !imem_ack_in) begin
                    target_r <= target_s;
                end else begin
                    fetch_pc_r <= target_s;
                end
            end else if (state_r == DRAIN) begin
                if (ack_s) begin
                    fetch_pc_r <= target_r;
                end
            end else begin
                if (ack_s) begin
                    fetch_pc_r  <= fetch_pc_r + 32'd4;
                    ispb_pend_r <= 1'b0;
                end
                if (pop_s) begin
                    i_out          <= fifo_data_r[0];
                    pc_out         <= fifo_pc_r[0];
                    ispb_out       <= fifo_pb_r[0];
                    i_valid_out    <= 1'b1;
                    fifo_data_r[0] <= fifo_data_r[1];
                    fifo_pc_r[0]   <= fifo_pc_r[1];
                    fifo_pb_r[0]   <= fifo_pb_r[1];
                end else if (out_free_s && ack_s) begin
                    i_out       <= imem_data_in;
                    pc_out      <= fetch_pc_r;
                    ispb_out    <= ispb_pend_r;
                    i_valid_out <= 1'b1;
                end else if (out_free_s) begin
                    i_valid_out <= 1'b0;
                    ispb_out    <= 1'b0;
                end
                if (push_s) begin
                    fifo_data_r[wr_idx_s] <= imem_data_in;
                    fifo_pc_r[wr_idx_s]   <= fetch_pc_r;
                    fifo_pb_r[wr_idx_s]   <= ispb_pend_r;
                end
                fifo_cnt_r <= fifo_cnt_r - {1'b0, pop_s} + {1'b0, push_s};
            end
`else
            if (ack_s) begin
                i_out       <= imem_data_in;
                pc_out      <= fetch_pc_r;
                i_valid_out <= 1'b1;
                ispb_out    <= ispb_pend_r;
                ispb_pend_r <= 1'b0;
            end else if (consume_s) begin
                i_valid_out <= 1'b0;
                ispb_out    <= 1'b0;
                if (ib_in) begin
                    fetch_pc_r  <= target_s;
                    ispb_pend_r <= 1'b1;
                end else begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end
            end
`endif
        end
    end

endmodule
